// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator, one pixel per clk.
// Horizontal and vertical counters walk the full raster. Every output is a
// combinational decode of those registered counters, so all outputs refer to
// the same pixel.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        o_draw_active,
  output logic [$clog2(H_ACTIVE)-1:0] o_active_x,
  output logic [$clog2(V_ACTIVE)-1:0] o_active_y,
  output logic                        o_h_sync,
  output logic                        o_v_sync
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_in_sync;
  logic          v_in_sync;

  // Raster position. Reset wins over counting; the line counter advances
  // only as the pixel counter wraps, so v_sync moves only on h_cnt=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Decode of the current position; coordinates are zeroed outside the
  // visible window so the frame-buffer side never sees blanking addresses.
  always_comb begin
    o_draw_active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    o_active_x    = '0;
    o_active_y    = '0;
    if (o_draw_active) begin
      o_active_x = h_cnt[XW-1:0];
      o_active_y = v_cnt[YW-1:0];
    end
    h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
    v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);
    o_h_sync  = h_in_sync ? SYNC_POL : ~SYNC_POL;
    o_v_sync  = v_in_sync ? SYNC_POL : ~SYNC_POL;
  end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: small raster (32x19) so several whole frames fit in a
// short run. The reference tracks a single linear pixel index within the
// frame and derives line/column with division and modulo.
module tb_vga_timing;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 10, VF = 2, VS = 3, VB = 4;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct {
    int draw;
    int x;
    int y;
    int hs;
    int vs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic                    draw_active;
  logic [$clog2(HA)-1:0]   active_x;
  logic [$clog2(VA)-1:0]   active_y;
  logic                    h_sync;
  logic                    v_sync;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  int pix = 0;

  vga_timing #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .o_draw_active(draw_active), .o_active_x(active_x), .o_active_y(active_y),
    .o_h_sync(h_sync), .o_v_sync(v_sync)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int p);
    exp_t e;
    int h, v;
    h = p % HT;
    v = p / HT;
    e.draw = (h < HA && v < VA) ? 1 : 0;
    e.x    = e.draw ? h : 0;
    e.y    = e.draw ? v : 0;
    e.hs   = (h >= HA + HF && h < HA + HF + HS) ? 0 : 1;
    e.vs   = (v >= VA + VF && v < VA + VF + VS) ? 0 : 1;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp, input int p);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s pix=%0d got=%0d expected=%0d", name, p, act, exp);
    end
  endtask

  // One clock: rst is applied for this edge, model advances, expectation queued.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    pix = r ? 0 : (pix + 1) % FRAME;
    sb.push_back(model(pix));
    #1;
  endtask

  // Monitor: the design outputs every cycle, so one expectation per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("draw_active", int'(draw_active), e.draw, pix);
      chk("active_x",    int'(active_x),    e.x,    pix);
      chk("active_y",    int'(active_y),    e.y,    pix);
      chk("h_sync",      int'(h_sync),      e.hs,   pix);
      chk("v_sync",      int'(v_sync),      e.vs,   pix);
    end
  end

  initial begin
    #1;
    repeat (3) step(1'b1);
    // Three full frames undisturbed: covers line ends, sync windows, frame wrap.
    repeat (3 * FRAME) step(1'b0);
    // Directed mid-line, mid-frame reset.
    while (pix != 5 * HT + 13) step(1'b0);
    step(1'b1);
    repeat (2 * HT) step(1'b0);
    // Reset landing inside the vertical sync window.
    while (pix != (VA + VF + 1) * HT + HA + HF + 2) step(1'b0);
    step(1'b1);
    // Random traffic with sparse resets, some held several cycles.
    repeat (3000) step(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    repeat (FRAME + 5) step(1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
